// File: rtl/ring_boundary_buffer_pkg.sv
// Shared definitions for the ring boundary buffer: default flit geometry and
// the helper that extracts the in-band valid flag from a flit.
package ring_boundary_buffer_pkg;

  localparam int RING_FLIT_W    = 144;
  localparam int RING_VALID_BIT = 0;

  // Widest flit the helper accepts; narrower flits are zero-extended by the caller.
  localparam int FLIT_W_MAX = 1024;
  localparam int VBIT_W     = $clog2(FLIT_W_MAX);

  function automatic logic flit_valid(input logic [FLIT_W_MAX-1:0] flit,
                                      input logic [VBIT_W-1:0]     vbit);
    return flit[vbit];
  endfunction

endpackage

// File: rtl/ring_boundary_buffer_fifo.sv
// One channel of the boundary buffer: DEPTH-entry flit queue with a registered
// stall toward the sender (one skid slot) and a sticky overflow flag.
module boundary_fifo
  import ring_boundary_buffer_pkg::*;
#(
  parameter int FLIT_W = RING_FLIT_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              push_req,
  input  logic              stall_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              stall_out,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SKID_CNT = CNT_W'(DEPTH - 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              pop;
  logic              push;
  logic              drop;

  // A full queue still accepts a flit when the head leaves in the same cycle.
  always_comb begin
    pop        = (count != '0) && !stall_in;
    push       = push_req && ((count != FULL_CNT) || pop);
    drop       = push_req && !push;
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_next;
      stall_out <= (count_next >= SKID_CNT);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared; the counters alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  assign flit_out = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ring_boundary_buffer.sv
// NCH-channel boundary stage between local and global rings. Optional
// zero-latency bypass of an empty, unstalled channel under BOUNDARY_BYPASS_EN.
module ring_boundary_buffer
  import ring_boundary_buffer_pkg::*;
#(
  parameter int FLIT_W    = RING_FLIT_W,
  parameter int VALID_BIT = RING_VALID_BIT,
  parameter int NCH       = 2,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*FLIT_W-1:0] port_ci,
  output logic [NCH*FLIT_W-1:0] port_co,
  input  logic [NCH-1:0]        stall_in,
  output logic [NCH-1:0]        stall_out,
  output logic [NCH-1:0]        overflow
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [FLIT_W-1:0] ch_in;
    logic [FLIT_W-1:0] fifo_out;
    logic              ch_valid;
    logic              push_req;

    assign ch_in    = port_ci[c*FLIT_W +: FLIT_W];
    assign ch_valid = flit_valid(FLIT_W_MAX'(ch_in), VBIT_W'(VALID_BIT));

    boundary_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flit_in   (ch_in),
      .push_req  (push_req),
      .stall_in  (stall_in[c]),
      .flit_out  (fifo_out),
      .stall_out (stall_out[c]),
      .overflow  (overflow[c])
    );

`ifdef BOUNDARY_BYPASS_EN
    // Queued flits are always valid, so an invalid head means the queue is empty.
    logic head_valid;
    logic bypass;

    assign head_valid = flit_valid(FLIT_W_MAX'(fifo_out), VBIT_W'(VALID_BIT));
    assign bypass     = !head_valid && !stall_in[c] && ch_valid;
    assign push_req   = ch_valid && !bypass;
    assign port_co[c*FLIT_W +: FLIT_W] = bypass ? ch_in : fifo_out;
`else
    assign push_req = ch_valid;
    assign port_co[c*FLIT_W +: FLIT_W] = fifo_out;
`endif
  end

endmodule

// File: tb/tb_ring_boundary_buffer.sv
// Directed and randomized-stall bench for ring_boundary_buffer (NCH=4, DEPTH=4)
// with a per-channel scoreboard consumed by a negedge output monitor.
module tb_ring_boundary_buffer;

  localparam int W     = 144;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [NCH*W-1:0] port_ci;
  logic [NCH*W-1:0] port_co;
  logic [NCH-1:0]   stall_in;
  logic [NCH-1:0]   stall_out;
  logic [NCH-1:0]   overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [NCH][$];
  logic [W-1:0] prev_out [NCH];
  bit           prev_held [NCH];

  ring_boundary_buffer #(
    .FLIT_W    (W),
    .VALID_BIT (0),
    .NCH       (NCH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .port_ci   (port_ci),
    .port_co   (port_co),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel id and tag byte up top, tag repeated in the low byte (odd => valid).
  function automatic logic [W-1:0] mk_flit(input int c, input logic [7:0] lo);
    return {8'(c), lo, $urandom(), $urandom(), $urandom(), 24'hA5C3E1, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int c, input logic [W-1:0] f, input bit accept);
    port_ci[c*W +: W] = f;
    if (accept) exp_q[c].push_back(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A flit is consumed at the edge that follows a cycle where it is shown unstalled.
  always @(negedge clk) begin : monitor
    logic [W-1:0] f;
    logic [W-1:0] e;
    for (int c = 0; c < NCH; c++) begin
      f = port_co[c*W +: W];
      if (rst) begin
        prev_held[c] = 1'b0;
      end else begin
        if (prev_held[c]) checkOutput("held_flit", f, prev_out[c]);
        if (f[0] !== 1'b1) begin
          checkOutput("idle_zero", f, '0);
        end else if (!stall_in[c]) begin
          if (exp_q[c].size() == 0) begin
            checkOutput("unexpected_flit", f, '0);
          end else begin
            e = exp_q[c].pop_front();
            checkOutput("fifo_order", f, e);
          end
        end
        prev_held[c] = (f[0] === 1'b1) && stall_in[c];
        prev_out[c]  = f;
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] f1;
    int sent [NCH];
    int total;
    int guard;

    rst      = 1'b1;
    port_ci  = '0;
    stall_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NCH; c++) checkOutput("reset_port_co", port_co[c*W +: W], '0);
    checkOutput("reset_stall_out", W'(stall_out), '0);
    checkOutput("reset_overflow", W'(overflow), '0);

    // Single flit on channel 0
    f1 = 144'h0123456789abcdef0123456789abcdef1851;
    applyStimulus(0, f1, 1'b1);
`ifdef BOUNDARY_BYPASS_EN
    #1 checkOutput("single_bypass", port_co[0 +: W], f1);
`endif
    tick();
    applyStimulus(0, '0, 1'b0);
`ifndef BOUNDARY_BYPASS_EN
    checkOutput("single_latency", port_co[0 +: W], f1);
`endif
    checkOutput("single_ch1_idle", port_co[W +: W], '0);
    repeat (3) tick();

    // Backpressure fill: stall_out rises after the third flit, fourth uses the skid slot
    stall_in[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, mk_flit(0, 8'(2*i + 1)), 1'b1);
      tick();
      checkOutput("fill_stall_out", W'(stall_out[0]), W'(i >= 2));
    end
    applyStimulus(0, '0, 1'b0);
    checkOutput("fill_overflow", W'(overflow[0]), '0);
    repeat (2) tick();
    stall_in[0] = 1'b0;
    repeat (6) tick();
    checkOutput("fill_drained", W'(exp_q[0].size()), '0);
    checkOutput("fill_stall_release", W'(stall_out[0]), '0);

    // Full queue with simultaneous push and pop
    stall_in[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, mk_flit(0, 8'(8'h21 + 2*i)), 1'b1);
      tick();
    end
    applyStimulus(0, mk_flit(0, 8'h29), 1'b1);
    stall_in[0] = 1'b0;
    tick();
    applyStimulus(0, '0, 1'b0);
    stall_in[0] = 1'b1;
    checkOutput("pushpop_overflow", W'(overflow[0]), '0);
    checkOutput("pushpop_stall_out", W'(stall_out[0]), W'(1));
    tick();
    stall_in[0] = 1'b0;
    repeat (6) tick();
    checkOutput("pushpop_drained", W'(exp_q[0].size()), '0);

    // Overflow: fifth flit ignores stall_out and is dropped; ch1 traffic unaffected
    stall_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, mk_flit(0, 8'(8'h11 + 2*i)), i < 4);
      if (i == 4) applyStimulus(1, mk_flit(1, 8'h61), 1'b1);
      tick();
    end
    applyStimulus(0, '0, 1'b0);
    applyStimulus(1, '0, 1'b0);
    checkOutput("ovf_set", W'(overflow[0]), W'(1));
    checkOutput("ovf_ch1_clear", W'(overflow[1]), '0);
    checkOutput("ovf_ch1_stall", W'(stall_out[1]), '0);
    stall_in[0] = 1'b0;
    repeat (6) tick();
    checkOutput("ovf_drained", W'(exp_q[0].size()), '0);
    checkOutput("ovf_sticky", W'(overflow[0]), W'(1));

    // Mid-operation reset discards queued flits and clears flags
    stall_in[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, mk_flit(0, 8'(8'h31 + 2*i)), 1'b1);
      tick();
    end
    applyStimulus(0, '0, 1'b0);
    checkOutput("pre_reset_stall_out", W'(stall_out[0]), W'(1));
    rst = 1'b1;
    exp_q[0].delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) checkOutput("midreset_port_co", port_co[c*W +: W], '0);
    checkOutput("midreset_stall_out", W'(stall_out), '0);
    checkOutput("midreset_overflow", W'(overflow), '0);
    stall_in[0] = 1'b0;
    repeat (4) tick();

    // Parallel channels with random downstream stalls and a compliant sender
    for (int c = 0; c < NCH; c++) sent[c] = 0;
    total = 0;
    guard = 0;
    while (total < NCH*8 && guard < 400) begin
      for (int c = 0; c < NCH; c++) begin
        stall_in[c] = ($urandom_range(0, 2) == 0);
        if (sent[c] < 8 && !stall_out[c] && $urandom_range(0, 3) != 0) begin
          applyStimulus(c, mk_flit(c, 8'(2*sent[c] + 1)), 1'b1);
          sent[c]++;
          total++;
        end else begin
          applyStimulus(c, '0, 1'b0);
        end
      end
      tick();
      guard++;
    end
    checkOutput("parallel_sent", W'(total), W'(NCH*8));
    port_ci  = '0;
    stall_in = '0;
    repeat (10) tick();
    for (int c = 0; c < NCH; c++) checkOutput("parallel_drained", W'(exp_q[c].size()), '0);
    checkOutput("parallel_overflow", W'(overflow), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
